// File: rtl/sc_ctrl_pkg.sv
// Shared types and LFSR helpers for the stochastic-computing edge array control.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package sc_ctrl_pkg;

  // Frame sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } sc_ctrl_state_t;

  // Feedback taps for x^16+x^14+x^13+x^11+1 on a left-shifting register:
  // bits 15, 13, 12 and 10. The pixel SNGs reuse this mask.
  localparam logic [15:0] LFSR_TAP_MASK = 16'hB400;

  // An all-zero LFSR state locks up, so a zero seed is replaced by this value.
  localparam logic [15:0] LFSR_ZERO_SUB = 16'h0001;

  // Feedback bit shifted into bit 0 on the next advance.
  function automatic logic lfsr16_fb(input logic [15:0] cur);
    return ^(cur & LFSR_TAP_MASK);
  endfunction

  // One Fibonacci step, shifting left.
  function automatic logic [15:0] lfsr16_step(input logic [15:0] cur);
    return {cur[14:0], lfsr16_fb(cur)};
  endfunction

  // Seed with the lock-up state removed.
  function automatic logic [15:0] lfsr16_seed_fix(input logic [15:0] seed);
    return (seed == 16'h0000) ? LFSR_ZERO_SUB : seed;
  endfunction

endpackage

// File: rtl/sc_lfsr16.sv
// 16-bit Fibonacci LFSR with synchronous reload; shared by the controller and the pixel SNGs.
// Latency: q reflects a load or advance one clock after load/en is sampled.
// Backpressure: none; en simply freezes the state.
module sc_lfsr16
  import sc_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        en,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  // Reload on reset or load, otherwise step once per enabled cycle.
  always_ff @(posedge clk) begin
    if (reset || load) begin
      q <= lfsr16_seed_fix(seed);
    end else if (en) begin
      q <= lfsr16_step(q);
    end
  end

endmodule

// File: rtl/sc_edge_ctrl.sv
// Frame sequencer for the SC Roberts-cross array: load SNGs, run len bitstream cycles, drain, hand off.
// Latency: sng_load at t+1 after start edge t, sng_en t+2..t+1+len, res_valid from t+2+len+PIPE_LAT.
// Backpressure: res_valid holds in DONE until res_ready; start while busy is dropped, not queued.
module sc_edge_ctrl
  import sc_ctrl_pkg::*;
#(
  parameter int          LEN_W     = 10,
  parameter int          PIPE_LAT  = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             sng_load,
  output logic             sng_en,
  output logic             sel,
  output logic             cnt_clr,
  output logic             cnt_en,
  output logic             res_valid,
  input  logic             res_ready
);

  // Remaining-count register is one bit wider so that len==0 can mean 2^LEN_W.
  localparam int               CNT_W      = LEN_W + 1;
  localparam logic [CNT_W-1:0] LEN_MAX    = {1'b1, {LEN_W{1'b0}}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{LEN_W{1'b0}}, 1'b1};
  localparam int               DRN_W      = 3;
  localparam logic [DRN_W-1:0] DRAIN_LAST = DRN_W'(PIPE_LAT - 1);
  localparam logic [15:0]      SEED_EFF   = lfsr16_seed_fix(LFSR_SEED);

  sc_ctrl_state_t       state_q;
  sc_ctrl_state_t       state_d;
  logic [CNT_W-1:0]     rem_q;
  logic [DRN_W-1:0]     drn_q;
  logic [PIPE_LAT-1:0]  pipe_q;
  logic [15:0]          lfsr_q;
  logic                 abort_hit;
  logic                 run_last;

  // abort only has meaning while a frame is in flight.
  assign abort_hit = abort && (state_q != ST_IDLE);
  assign run_last  = (rem_q == CNT_ONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection and output decode from the registered state.
  always_comb begin
    state_d   = state_q;
    busy      = 1'b1;
    sng_load  = 1'b0;
    sng_en    = 1'b0;
    cnt_clr   = 1'b0;
    res_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        sng_load = 1'b1;
        cnt_clr  = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        sng_en = 1'b1;
        if (run_last) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (drn_q == '0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        res_valid = 1'b1;
        if (res_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Abort wins over every other transition, including a DONE handshake.
    if (abort_hit) begin
      state_d = ST_IDLE;
    end
  end

  // Remaining bitstream cycles: latched on an accepted start, counted down in RUN.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      rem_q <= (len == '0) ? LEN_MAX : {1'b0, len};
    end else if (state_q == ST_RUN) begin
      rem_q <= rem_q - CNT_ONE;
    end
  end

  // Drain counter: armed throughout RUN so DRAIN starts at PIPE_LAT-1 and exits at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      drn_q <= '0;
    end else if (state_q == ST_RUN) begin
      drn_q <= DRAIN_LAST;
    end else if ((state_q == ST_DRAIN) && (drn_q != '0)) begin
      drn_q <= drn_q - 1'b1;
    end
  end

  // Delay line matching the array latency, so the counters see only valid output bits.
  always_ff @(posedge clk) begin
    if (reset || abort_hit || (state_q == ST_LOAD)) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= (pipe_q << 1) | PIPE_LAT'(sng_en);
    end
  end

  assign cnt_en = pipe_q[PIPE_LAT-1];

  // Select-line generator, reloaded every frame so each frame sees the same sel sequence.
  sc_lfsr16 u_sel_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (sng_load),
    .en    (sng_en),
    .seed  (SEED_EFF),
    .q     (lfsr_q)
  );

  // sel mirrors the LFSR bit 0 during RUN: it takes the seed bit entering the first RUN
  // cycle and the next LFSR bit entering each later one, so it only moves into RUN
  // cycles and holds through DRAIN, DONE and IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel <= SEED_EFF[0];
    end else if (!abort_hit) begin
      if (state_q == ST_LOAD) begin
        sel <= SEED_EFF[0];
      end else if ((state_q == ST_RUN) && !run_last) begin
        sel <= lfsr16_fb(lfsr_q);
      end
    end
  end

endmodule

// File: tb/tb_sc_edge_ctrl.sv
// Self-checking bench for sc_edge_ctrl with a per-frame scoreboard.
// Frames expected to complete push an entry at start; the monitor pops it when res_valid rises.
// Inputs are driven 1 time unit after posedge, outputs sampled there and at negedge.
module tb_sc_edge_ctrl;

  localparam int          LEN_W = 4;
  localparam int          PIPE  = 1;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy, sng_load, sng_en, sel, cnt_clr, cnt_en, res_valid;
  logic             res_ready;

  always #5 clk = ~clk;

  sc_edge_ctrl #(
    .LEN_W     (LEN_W),
    .PIPE_LAT  (PIPE),
    .LFSR_SEED (SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .len       (len),
    .abort     (abort),
    .busy      (busy),
    .sng_load  (sng_load),
    .sng_en    (sng_en),
    .sel       (sel),
    .cnt_clr   (cnt_clr),
    .cnt_en    (cnt_en),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  typedef struct {
    int          len_eff;
    logic [15:0] sel_bits;
  } frame_exp_t;

  frame_exp_t  sb_q[$];
  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] seed_v = SEED;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference LFSR: taps 16,14,13,11 -> bits 15,13,12,10, shift left.
  function automatic logic [15:0] ref_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic frame_exp_t mk_exp(input int l);
    frame_exp_t  e;
    logic [15:0] s;
    e.len_eff  = (l == 0) ? (1 << LEN_W) : l;
    e.sel_bits = '0;
    s = seed_v;
    for (int i = 0; i < e.len_eff; i++) begin
      e.sel_bits[i] = s[0];
      s = ref_step(s);
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int l, input bit expect_done);
    start = 1'b1;
    len   = l[LEN_W-1:0];
    if (expect_done) sb_q.push_back(mk_exp(l));
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    chk("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  // Frame monitor: measures each frame from its sng_load cycle and scores it at res_valid.
  logic        mon_act = 1'b0;
  int          m_cyc, m_ne, m_nc, m_fen, m_fcn;
  logic [15:0] m_sel;
  logic        prev_sel;
  logic        prev_rst = 1'b1;
  frame_exp_t  m_e;

  always @(negedge clk) begin
    if (reset) begin
      mon_act = 1'b0;
    end else begin
      if (!prev_rst && !sng_en) chk("sel_hold", {31'b0, sel}, {31'b0, prev_sel});
      if (sng_load) begin
        mon_act = 1'b1;
        m_cyc = 0; m_ne = 0; m_nc = 0; m_fen = -1; m_fcn = -1;
        m_sel = '0;
      end else if (mon_act) begin
        m_cyc++;
        if (sng_en) begin
          if (m_fen < 0) m_fen = m_cyc;
          if (m_ne < 16) m_sel[m_ne] = sel;
          m_ne++;
        end
        if (cnt_en) begin
          if (m_fcn < 0) m_fcn = m_cyc;
          m_nc++;
        end
        if (res_valid) begin
          mon_act = 1'b0;
          if (sb_q.size() == 0) begin
            chk("unexp_valid", 32'd1, 32'd0);
          end else begin
            m_e = sb_q.pop_front();
            chk("sng_en_cnt",   m_ne,  m_e.len_eff);
            chk("cnt_en_cnt",   m_nc,  m_e.len_eff);
            chk("sng_en_first", m_fen, 1);
            chk("cnt_en_first", m_fcn, 1 + PIPE);
            chk("valid_lat",    m_cyc, m_e.len_eff + PIPE + 1);
            chk("sel_seq",      {16'b0, m_sel}, {16'b0, m_e.sel_bits});
          end
        end else if (!busy) begin
          mon_act = 1'b0;
        end
      end
    end
    prev_sel = sel;
    prev_rst = reset;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int n;
    int loads[$];

    reset = 1'b1; start = 1'b0; abort = 1'b0; res_ready = 1'b1; len = '0;
    repeat (3) tick();
    chk("rst_outs", {26'b0, busy, sng_load, sng_en, cnt_clr, cnt_en, res_valid}, 32'd0);
    chk("rst_sel", {31'b0, sel}, {31'b0, seed_v[0]});
    reset = 1'b0;
    tick();

    // Basic frame, len=8.
    launch(8, 1'b1);
    chk("load_pulse", {31'b0, sng_load}, 32'd1);
    chk("load_clr",   {31'b0, cnt_clr},  32'd1);
    tick();
    chk("load_1cyc",  {31'b0, sng_load}, 32'd0);
    chk("run_en",     {31'b0, sng_en},   32'd1);
    wait_idle(40);

    // len=0 means 16; two frames must show the same sel sequence.
    launch(0, 1'b1);
    wait_idle(60);
    launch(0, 1'b1);
    wait_idle(60);

    // Abort in the third RUN cycle.
    launch(8, 1'b0);
    repeat (3) tick();
    chk("abort_in_run", {31'b0, sng_en}, 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle",  {31'b0, busy},   32'd0);
    chk("abort_cnten", {31'b0, cnt_en}, 32'd0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (res_valid || busy) seen = 1'b1;
    end
    chk("abort_no_valid", {31'b0, seen}, 32'd0);
    launch(5, 1'b1);
    wait_idle(40);

    // Result held in DONE while res_ready is low; start in DONE is dropped.
    res_ready = 1'b0;
    launch(3, 1'b1);
    n = 0;
    while (!res_valid && n < 30) begin
      tick();
      n++;
    end
    chk("done_reach", {31'b0, res_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      tick();
      start = 1'b0;
      chk("done_hold_valid", {31'b0, res_valid}, 32'd1);
      chk("done_hold_busy",  {31'b0, busy},      32'd1);
    end
    res_ready = 1'b1;
    tick();
    chk("done_exit", {30'b0, busy, res_valid}, 32'd0);
    repeat (3) tick();
    chk("no_queued_start", {30'b0, busy, sng_load}, 32'd0);

    // Reset in DRAIN with start high.
    launch(2, 1'b0);
    repeat (3) tick();
    chk("in_drain", {29'b0, busy, sng_en, res_valid}, 32'b100);
    reset = 1'b1;
    start = 1'b1;
    tick();
    chk("rst_mid_outs", {26'b0, busy, sng_load, sng_en, cnt_clr, cnt_en, res_valid}, 32'd0);
    chk("rst_mid_sel", {31'b0, sel}, {31'b0, seed_v[0]});
    reset = 1'b0;
    start = 1'b0;
    tick();
    chk("rst_no_launch", {30'b0, busy, sng_load}, 32'd0);
    tick();

    // start held high: back-to-back frames, len=4.
    start = 1'b1;
    len   = 4'd4;
    repeat (3) sb_q.push_back(mk_exp(4));
    for (int k = 1; k <= 17; k++) begin
      tick();
      if (sng_load) loads.push_back(k);
    end
    start = 1'b0;
    wait_idle(40);
    chk("b2b_frames", loads.size(), 3);
    if (loads.size() == 3) begin
      chk("b2b_space0", loads[1] - loads[0], 4 + PIPE + 3);
      chk("b2b_space1", loads[2] - loads[1], 4 + PIPE + 3);
    end

    repeat (3) tick();
    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sc_edge_ctrl.md
# sc_edge_ctrl

Frame sequencer for the stochastic-computing parallel Roberts-cross edge array. It accepts a start command and a bitstream length, then loads the pixel stochastic number generators (SNGs). It runs the array for the requested number of bitstream cycles while driving the shared `sel` line from an LFSR, and gates the downstream per-pixel ones-counters so they see exactly the array's valid output bits. Results are handed off with a valid/ready handshake.

## Interface
- `LEN_W`, 10: width of the bitstream-length input; maximum length is 2^LEN_W.
- `PIPE_LAT`, 1: register latency of the edge array from SNG bit to `out_bits`; legal range 1..4.
- `LFSR_SEED`, 16'hACE1: reload value for the `sel` LFSR; a zero seed is replaced by 16'h0001.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  frame request; sampled only in IDLE.
- `len`  in  LEN_W  bitstream cycles for the frame; latched when `start` is accepted; 0 encodes 2^LEN_W.
- `abort`  in  1  cancel the current frame; honoured in every state except IDLE.
- `busy`  out  1  high in every state except IDLE.
- `sng_load`  out  1  one-cycle pulse: SNGs latch pixel values and reseed.
- `sng_en`  out  1  SNGs advance one bit per cycle while high.
- `sel`  out  1  Roberts-cross XOR/mux select bit shared by all array cells.
- `cnt_clr`  out  1  clears the output counters (same cycle as `sng_load`).
- `cnt_en`  out  1  output counters accumulate `out_bits` this cycle.
- `res_valid`  out  1  counters hold a complete frame result.
- `res_ready`  in  1  downstream has consumed the result.

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE -> LOAD when `start`=1. `len` is latched into a LEN_W+1-bit remaining-count register, with 0 mapped to 2^LEN_W.
- LOAD (1 cycle): `sng_load`=1, `cnt_clr`=1, LFSR reloaded with the seed. Next state is RUN.
- RUN: `sng_en`=1; the remaining count decrements each cycle. Go to DRAIN in the cycle the count reaches 1, giving exactly `len` RUN cycles.
- DRAIN: lasts PIPE_LAT cycles, counted by a dedicated drain counter. Next state is DONE.
- DONE: `res_valid`=1 until `res_ready`=1, then IDLE. The handshake completes in the cycle both are high.
- `cnt_en` is `sng_en` delayed by PIPE_LAT cycles through a shift register that is cleared by `reset`, `abort` and LOAD. It is therefore high for exactly `len` cycles per frame.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1, shifts left.
  - Advances only while `sng_en`=1.
  - `sel` = lfsr[0], registered; `sel` changes only in RUN cycles.
  - Outside RUN, `sel` holds its last value.
- `abort` in LOAD, RUN, DRAIN or DONE -> IDLE on the next edge.
  - `res_valid` is not asserted for that frame (it drops on the same edge if it was already high in DONE).
  - The `cnt_en` pipe is flushed.
- `start` while `busy` is ignored; it is not queued.
- If `abort` and `res_ready` are both high in DONE, the cycle counts as an abort (same next state).

## Timing
- Reset values: state IDLE, `busy`=0, `sng_load`=0, `sng_en`=0, `cnt_clr`=0, `cnt_en`=0, `res_valid`=0, `sel`=LFSR_SEED[0], LFSR=seed.
- All outputs are registered, i.e. decoded from the registered state and counters with no combinational path from inputs to outputs.
- Latency from `start` accepted at edge t:
  - `sng_load` high in cycle t+1.
  - `sng_en` high in cycles t+2 .. t+1+len.
  - `cnt_en` high in cycles t+2+PIPE_LAT .. t+1+len+PIPE_LAT.
  - `res_valid` rises at cycle t+2+len+PIPE_LAT.
- Minimum frame-to-frame spacing: `len`+PIPE_LAT+3 cycles, with `res_ready` tied high.
- Reset asserted mid-frame: the next cycle is in the reset state regardless of the other inputs.

## Structure
- Package `sc_ctrl_pkg`: state enum `sc_ctrl_state_t` and the LFSR polynomial tap mask constant. The SNG blocks reuse the tap mask.
- One sub-module, `sc_lfsr16`, with ports `clk`, `reset`, `load`, `en`, `seed`, `q`. The SNGs can instantiate the same module.
- The controller holds only control and scalar counters. The per-pixel counters live outside this block.

## Test plan
- Reset, then `start` with `len`=8 and PIPE_LAT=1 -> `sng_load` for 1 cycle, `sng_en` for exactly 8 cycles, `cnt_en` for 8 cycles shifted by 1, and `res_valid` 11 cycles after the start edge.
- `len`=0 with LEN_W=4 -> 16 RUN cycles. Also check `sel` against a reference LFSR model from seed 16'hACE1: the first 16 `sel` values match, and two consecutive frames produce identical `sel` sequences.
- `abort` in the 3rd RUN cycle -> IDLE next cycle, `cnt_en` low within 1 cycle, `res_valid` never rises. A subsequent `start` runs a full, clean frame.
- `res_ready` held low for 5 cycles in DONE -> `res_valid` stays high and `busy`=1. `start` pulsed during DONE is ignored. `res_ready`=1 -> IDLE next cycle.
- `reset` asserted in DRAIN together with `start` -> all outputs at their reset values next cycle, and no frame is launched.
- `start` held continuously with `res_ready`=1 and `len`=4 -> back-to-back frames every 4+PIPE_LAT+3 cycles, each with exactly 4 `cnt_en` cycles.
